// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - PS/2 byte input, CPU read port and status bundle
//
// Purpose: groups every non-clock/reset signal of ps2_key_decoder.
//   master : the side that produces PS/2 bytes and reads the event FIFO
//   slave  : the decoder itself
// Signals:
//   ps2Data   [7:0]  received byte, quasi-static, PS/2 clock domain
//   ps2Update        byte-valid level, PS/2 clock domain
//   rd               pop head entry (ignored when empty)
//   clrErr           clear sticky overflow/kbdErr
//   keyCode   [7:0]  head entry scan code (first-word fall-through)
//   keyExt           head entry carried an E0 prefix
//   keyRel           head entry is a release (F0 prefix)
//   keyEmpty         FIFO empty
//   keyCount  [AW:0] entries held
//   overflow         sticky: event dropped on full FIFO
//   kbdErr           sticky: keyboard reported 00/FF
interface ps2_key_decoder_if #(
  parameter int AW = 3
);
  logic [7:0]  ps2Data;
  logic        ps2Update;
  logic        rd;
  logic        clrErr;
  logic [7:0]  keyCode;
  logic        keyExt;
  logic        keyRel;
  logic        keyEmpty;
  logic [AW:0] keyCount;
  logic        overflow;
  logic        kbdErr;

  modport master (
    output ps2Data, ps2Update, rd, clrErr,
    input  keyCode, keyExt, keyRel, keyEmpty, keyCount, overflow, kbdErr
  );

  modport slave (
    input  ps2Data, ps2Update, rd, clrErr,
    output keyCode, keyExt, keyRel, keyEmpty, keyCount, overflow, kbdErr
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set 2 prefix decoder with key-event FIFO
//
// Purpose: synchronises the PS/2 receiver's byte-valid level into clk,
// folds E0 / F0 / E1 prefix sequences into single key events and queues
// them in a first-word-fall-through FIFO for the CPU.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   ps2_key_decoder_if.slave (byte input, FIFO read port, status)
module ps2_key_decoder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  ps2_key_decoder_if.slave   bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    PFX_E0,
    PFX_F0,
    PFX_E0F0,
    SKIP
  } state_t;

  // ---------------------------------------------------------------
  // Update strobe synchroniser. Reset to all ones so an update level
  // that is already high when reset releases never looks like an edge.
  // ---------------------------------------------------------------
  logic s1, s2, s3;
  logic byte_strobe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= bus.ps2Update;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign byte_strobe = s2 & ~s3;

  // ps2Data is held by the receiver long after the update, so it is
  // used directly on the strobe cycle without its own synchroniser.
  logic [7:0] byte_in;
  assign byte_in = bus.ps2Data;

  // ---------------------------------------------------------------
  // Byte classification
  // ---------------------------------------------------------------
  logic is_err, is_house, is_fake_shift;

  assign is_err        = (byte_in == 8'h00) || (byte_in == 8'hFF);
  assign is_house      = byte_in inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'hFD};
  assign is_fake_shift = (byte_in == 8'h12) || (byte_in == 8'h59);

  // ---------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------
  state_t     state;
  logic [2:0] skip_cnt;
  logic       kbd_err;

  // The event must be written on the same edge the byte is consumed,
  // so the push decision is combinational from the current state.
  logic       push_req;
  logic [9:0] push_entry;

  always_comb begin
    push_req   = 1'b0;
    push_entry = {2'b00, byte_in};
    if (byte_strobe && !is_err) begin
      case (state)
        IDLE: begin
          if (!(byte_in inside {8'hE0, 8'hF0, 8'hE1}) && !is_house) begin
            push_req = 1'b1;
          end
        end
        PFX_E0: begin
          if (byte_in != 8'hF0 && !is_fake_shift) begin
            push_req   = 1'b1;
            push_entry = {2'b10, byte_in};
          end
        end
        PFX_F0: begin
          push_req   = 1'b1;
          push_entry = {2'b01, byte_in};
        end
        PFX_E0F0: begin
          if (!is_fake_shift) begin
            push_req   = 1'b1;
            push_entry = {2'b11, byte_in};
          end
        end
        SKIP: begin
          // The whole 8-byte Pause sequence collapses into one E1 event.
          if (skip_cnt == 3'd1) begin
            push_req   = 1'b1;
            push_entry = {2'b00, 8'hE1};
          end
        end
        default: begin
          push_req = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
      kbd_err  <= 1'b0;
    end else begin
      // Clear first so a simultaneous error byte below wins.
      if (bus.clrErr) begin
        kbd_err <= 1'b0;
      end
      if (byte_strobe) begin
        if (is_err) begin
          kbd_err <= 1'b1;
          state   <= IDLE;
        end else begin
          case (state)
            IDLE: begin
              if (byte_in == 8'hE0) begin
                state <= PFX_E0;
              end else if (byte_in == 8'hF0) begin
                state <= PFX_F0;
              end else if (byte_in == 8'hE1) begin
                state    <= SKIP;
                skip_cnt <= 3'd7;
              end
            end
            PFX_E0: begin
              state <= (byte_in == 8'hF0) ? PFX_E0F0 : IDLE;
            end
            PFX_F0, PFX_E0F0: begin
              state <= IDLE;
            end
            SKIP: begin
              skip_cnt <= skip_cnt - 3'd1;
              if (skip_cnt == 3'd1) begin
                state <= IDLE;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Event FIFO, entries {ext, rel, code}
  // ---------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          empty, full, pop, wr_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = bus.rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so natural
  // overflow of the adders provides the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        ovf <= 1'b1;
      end else if (bus.clrErr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign {bus.keyExt, bus.keyRel, bus.keyCode} = mem[rd_ptr];
  assign bus.keyEmpty = empty;
  assign bus.keyCount = count;
  assign bus.overflow = ovf;
  assign bus.kbdErr   = kbd_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst;

  ps2_key_decoder_if #(.AW(AW)) bus ();

  ps2_key_decoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [9:0] mq[$];
  logic [7:0] pend[$];
  bit         m_ov;
  bit         m_err;
  int         since_rise;
  bit         cmp_en;

  int errors;
  int checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void reset_model();
    mq.delete();
    pend.delete();
    m_ov  = 1'b0;
    m_err = 1'b0;
    since_rise = 100;
  endfunction

  // Decode from the byte history since the last event: a pending list of
  // prefix bytes decides what the final byte means.
  function automatic void model_decode(input logic [7:0] b, output bit push,
                                       output logic [9:0] e, output bit eset);
    bit ext, rel;
    push = 1'b0;
    e    = '0;
    eset = 1'b0;
    if (b == 8'h00 || b == 8'hFF) begin
      eset = 1'b1;
      pend.delete();
      return;
    end
    if (pend.size() == 0) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1}) begin
        pend.push_back(b);
      end else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'hFD})) begin
        push = 1'b1;
        e = {2'b00, b};
      end
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        push = 1'b1;
        e = {2'b00, 8'hE1};
        pend.delete();
      end
    end else if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) begin
      pend.push_back(b);
    end else begin
      ext = (pend[0] == 8'hE0);
      rel = (pend[pend.size()-1] == 8'hF0);
      if (!(ext && (b == 8'h12 || b == 8'h59))) begin
        push = 1'b1;
        e = {ext, rel, b};
      end
      pend.delete();
    end
  endfunction

  // One clock: the byte is taken on the 3rd rising edge with update high.
  task automatic step();
    bit got, pop, clr, push, eset, ovset, full_b;
    logic [7:0] b;
    logic [9:0] e;
    @(posedge clk);
    got = 1'b0;
    if (rst && bus.ps2Update) begin
      since_rise++;
      got = (since_rise == 3);
    end
    pop = bus.rd && (mq.size() > 0);
    clr = bus.clrErr;
    b   = bus.ps2Data;
    #1;
    if (!rst) return;
    push = 1'b0; eset = 1'b0; e = '0; ovset = 1'b0;
    if (got) model_decode(b, push, e, eset);
    full_b = (mq.size() == DEPTH);
    if (pop) mq.delete(0);
    if (push) begin
      if (!full_b || pop) mq.push_back(e);
      else ovset = 1'b1;
    end
    m_ov  = ovset | (m_ov & ~clr);
    m_err = eset  | (m_err & ~clr);
  endtask

  task automatic send(input logic [7:0] b, input bit rd_at_push = 1'b0);
    bus.ps2Data   = b;
    bus.ps2Update = 1'b1;
    since_rise    = 0;
    step();
    step();
    bus.rd = rd_at_push;
    step();
    bus.rd = 1'b0;
    step();
    bus.ps2Update = 1'b0;
    repeat (4) step();
  endtask

  task automatic pop_expect(input string name, input logic [9:0] exp);
    chk(name, {bus.keyExt, bus.keyRel, bus.keyCode}, exp);
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
  endtask

  task automatic clear_flags();
    bus.clrErr = 1'b1;
    step();
    bus.clrErr = 1'b0;
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en) begin
        chk("cyc_keyEmpty", bus.keyEmpty, mq.size() == 0);
        chk("cyc_keyCount", bus.keyCount, mq.size());
        chk("cyc_overflow", bus.overflow, m_ov);
        chk("cyc_kbdErr", bus.kbdErr, m_err);
        if (mq.size() > 0) chk("cyc_head", {bus.keyExt, bus.keyRel, bus.keyCode}, mq[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    cmp_en = 1'b0;
    rst = 1'b0;
    bus.ps2Data = 8'h00;
    bus.ps2Update = 1'b0;
    bus.rd = 1'b0;
    bus.clrErr = 1'b0;
    reset_model();
    repeat (3) step();
    cmp_en = 1'b1;
    chk("rst_keyEmpty", bus.keyEmpty, 1);
    chk("rst_keyCount", bus.keyCount, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_kbdErr", bus.kbdErr, 0);
    rst = 1'b1;
    repeat (2) step();

    // 1: A press and release
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("t1_count", bus.keyCount, 2);
    pop_expect("t1_press", 10'h01C);
    pop_expect("t1_release", 10'h11C);
    chk("t1_empty", bus.keyEmpty, 1);

    // 2: extended keys and fake shift
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'h7C);
    chk("t2_count", bus.keyCount, 3);
    pop_expect("t2_up_make", 10'h275);
    pop_expect("t2_up_break", 10'h375);
    pop_expect("t2_prtsc", 10'h27C);

    // 3: Pause sequence
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("t3_count7", bus.keyCount, 0);
    send(8'h77);
    chk("t3_count8", bus.keyCount, 1);
    send(8'h1C);
    pop_expect("t3_pause", 10'h0E1);
    pop_expect("t3_after", 10'h01C);

    // 4: overflow and push+pop at full
    for (int i = 0; i < DEPTH + 2; i++) send(8'h15 + 8'(i));
    chk("t4_count_full", bus.keyCount, DEPTH);
    chk("t4_overflow", bus.overflow, 1);
    chk("t4_head", {bus.keyExt, bus.keyRel, bus.keyCode}, 10'h015);
    send(8'h2A, 1'b1);
    chk("t4_count_pp", bus.keyCount, DEPTH);
    chk("t4_head_pp", {bus.keyExt, bus.keyRel, bus.keyCode}, 10'h016);
    clear_flags();
    chk("t4_ovf_clr", bus.overflow, 0);
    for (int i = 0; i < DEPTH - 1; i++) pop_expect("t4_drain", 10'h016 + 10'(i));
    pop_expect("t4_tail", 10'h02A);
    chk("t4_empty", bus.keyEmpty, 1);

    // 5: housekeeping and keyboard errors
    send(8'hAA); send(8'hFA); send(8'hFF);
    chk("t5_count", bus.keyCount, 0);
    chk("t5_kbdErr", bus.kbdErr, 1);
    clear_flags();
    chk("t5_kbdErr_clr", bus.kbdErr, 0);
    send(8'hF0); send(8'h00);
    chk("t5_kbdErr2", bus.kbdErr, 1);
    chk("t5_count2", bus.keyCount, 0);
    send(8'h1C);
    pop_expect("t5_press", 10'h01C);
    clear_flags();

    // 6: reset mid-prefix with update held high across release
    send(8'hE0);
    rst = 1'b0;
    reset_model();
    bus.ps2Data = 8'h1C;
    bus.ps2Update = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    repeat (5) step();
    chk("t6_no_spurious", bus.keyCount, 0);
    bus.ps2Update = 1'b0;
    repeat (4) step();
    bus.ps2Update = 1'b1;
    since_rise = 0;
    step();
    chk("t6_lat_edge1", bus.keyEmpty, 1);
    step();
    chk("t6_lat_edge2", bus.keyEmpty, 1);
    step();
    chk("t6_lat_edge3", bus.keyEmpty, 0);
    step();
    bus.ps2Update = 1'b0;
    repeat (4) step();
    pop_expect("t6_press", 10'h01C);
    repeat (2) step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Downstream of the PS/2 byte receiver. Takes its received bytes and per-byte update strobe, which live in the PS/2 clock domain.
- Brings the strobe into the system clock domain and decodes scan-code Set 2 prefix sequences (E0 extended, F0 break, E1 Pause) into single key events.
- Queues events in a small FWFT FIFO read by the CPU I/O port.
- Drops keyboard housekeeping bytes and flags keyboard-reported errors.

Parameters:
DEPTH, 8, FIFO entries; power of two, ≥2
AW, 3, log2(DEPTH); pointer width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
ps2Data  in  8  received byte from the PS/2 receiver; stable while ps2Update is high and for ≥8 PS/2 clocks after
ps2Update  in  1  receiver byte-valid level, PS/2 clock domain, high ≥1 PS/2 clock period per byte
rd  in  1  pop head entry; ignored when keyEmpty
clrErr  in  1  clear sticky overflow/kbdErr flags
keyCode  out  8  head entry code (FWFT)
keyExt  out  1  head entry had E0 prefix
keyRel  out  1  head entry is a release (F0 prefix)
keyEmpty  out  1  FIFO empty
keyCount  out  AW+1  entries held, 0..DEPTH
overflow  out  1  sticky: event dropped because FIFO full
kbdErr  out  1  sticky: keyboard sent 00 or FF (its buffer overrun)

Behaviour:
- Reset (rst=0, async): FIFO pointers and count = 0, keyEmpty=1, overflow=0, kbdErr=0, decoder state IDLE, skip counter 0. Sync regs s1/s2/s3 reset to 1, so an update already high at release does not produce a capture.
- Sync: s1<=ps2Update, s2<=s1, s3<=s2. byteStrobe = s2 & ~s3. ps2Data is sampled on the strobe cycle, not synchronised; it is quasi-static.
- Decoder acts only on byteStrobe. Entry written at the same edge. keyEmpty falls at the 3rd rising clk edge after ps2Update rises.
- Decoder states: IDLE, E0, F0, E0F0, SKIP. Register skipCnt is 3 bits.
  - IDLE:
    - E0 -> E0; F0 -> F0.
    - E1 -> SKIP with skipCnt=7.
    - 00/FF -> set kbdErr, stay.
    - FA, AA, EE, FE, FC, FD -> discard, stay.
    - Any other byte -> push {ext=0, rel=0, code}.
  - E0: F0 -> E0F0; 12 or 59 (fake shift) -> discard, IDLE; any other -> push {1, 0, code}, IDLE.
  - F0: any byte -> push {0, 1, code}, IDLE.
  - E0F0: 12 or 59 -> discard, IDLE; any other -> push {1, 1, code}, IDLE.
  - SKIP: decrement skipCnt per byte. On the byte that takes it to 0, push {0, 0, E1} (one Pause event) and go to IDLE.
  - 00/FF in any non-IDLE state: set kbdErr, go to IDLE, no push.
- FIFO: entries are 10 bits {ext, rel, code}. Head drives keyCode/keyExt/keyRel combinationally; outputs are don't-care when empty.
  - pop = rd & ~keyEmpty.
  - push when full and no pop -> entry dropped, overflow set.
  - push and pop in the same cycle: both happen, count unchanged, including at full.
  - Pointers wrap modulo DEPTH.
- Sticky flags: clrErr clears overflow and kbdErr. If a set event coincides with clrErr, set wins.
- No combinational path from rd to keyEmpty/keyCount. Both are registered or derived from registered count.

Test Plan:
1. Bytes 1C; F0 1C (A press, release) -> two entries {0,0,1C}, {0,1,1C}; keyCount=2; rd twice -> keyEmpty=1.
2. E0 75 then E0 F0 75 (Up arrow) -> {1,0,75}, {1,1,75}. E0 12 E0 7C -> only {1,0,7C} queued.
3. E1 14 77 E1 F0 14 F0 77 -> exactly one entry {0,0,E1} after the 8th byte; then 1C -> {0,0,1C}.
4. DEPTH+2 distinct make codes, no rd -> keyCount=DEPTH, overflow=1, head = first code. Pulse rd together with a push at full -> count stays DEPTH, new code at tail. clrErr -> overflow=0.
5. AA, FA, then FF -> nothing queued, kbdErr=1. F0 then 00 -> kbdErr=1, state IDLE, next 1C queued as press.
6. rst low after E0 received, ps2Update held high across release -> no spurious entry. Next 1C queued as {0,0,1C} (prefix forgotten). Latency: keyEmpty falls at the 3rd clk edge after ps2Update rises.
